collision_scanner: RTL and testbench
====================================

# collision_scanner

Parametrised multi-bullet collision detector for the battle box. Once per frame it snapshots the player position and N bullet positions, scans one bullet per clock against a circular hit radius, and reports a per-bullet hit mask plus a single collision event. A built-in invulnerability timer, counted in frames, suppresses repeated damage after a hit. It sits between the bullet pattern generators and the HP/game-state logic.

## Interface
- N_BULLETS, 8: number of bullet channels (≥1).
- COORD_W, 10: coordinate width in pixels, unsigned.
- RADIUS, 15: hit radius. Hit when dx²+dy² ≤ RADIUS².
- INVULN_FRAMES, 60: frames of invulnerability after an accepted collision (≥1, ≤255).
- clk, input, 1: system clock.
- reset, input, 1: synchronous, active-high reset.
- frame_tick, input, 1: one-cycle pulse at start of frame; starts a scan and decrements the invulnerability counter.
- player_x, player_y, input, COORD_W each: player centre.
- bullet_x, bullet_y, input, N_BULLETS*COORD_W each: packed bullet centres, channel k at bits [k*COORD_W +: COORD_W].
- bullet_active, input, N_BULLETS: per-channel enable. Inactive channels never hit.
- busy, output, 1: scan in progress.
- done, output, 1: one-cycle pulse when results are valid.
- hit_mask, output, N_BULLETS: channels that overlapped the player in the last scan.
- hit_index, output, clog2(N_BULLETS) (minimum 1): lowest hit channel in the last scan, 0 if none.
- collision, output, 1: one-cycle pulse, coincident with done, when any channel hit and the player is not invulnerable.
- invulnerable, output, 1: invulnerability counter is non-zero.
- hit_count, output, 8: accepted collisions, saturating at 255.

## Operation
- FSM has three states: IDLE, SCAN, REPORT.
- IDLE: frame_tick=1 snapshots player_x/y, bullet_x/y and bullet_active into registers, clears the scan index and hit accumulator, and moves to SCAN.
- SCAN: each cycle evaluates channel idx from the snapshot and ORs the result into accumulator bit idx. After idx = N_BULLETS-1, moves to REPORT.
- Arithmetic:
  - dx = |px − bx| and dy = |py − by|, formed as true absolute differences (not wrapped unsigned subtraction), each COORD_W bits.
  - Squares are 2*COORD_W bits; the sum is 2*COORD_W+1 bits.
  - The sum is compared ≤ RADIUS² with no overflow or truncation.
- REPORT, one cycle:
  - hit_mask ← accumulator.
  - hit_index ← lowest set bit (0 if none).
  - done=1.
  - If any bit is set and invulnerable=0: collision=1, invuln counter ← INVULN_FRAMES, hit_count += 1 (saturating).
  - Next state is IDLE.
- Invulnerability counter: on each frame_tick, decrements if non-zero, in any FSM state. If a counter load and a frame_tick decrement fall on the same cycle, the load wins.
- While invulnerable, scans still run and hit_mask/hit_index still update. Only collision and hit_count are suppressed.
- frame_tick while busy=1 is ignored for scan start and is not queued. It still decrements the invuln counter.
- Reset, including mid-scan:
  - FSM goes to IDLE.
  - busy, done, collision, invulnerable = 0.
  - hit_mask, hit_index, hit_count and invuln counter = 0.
  - Any partial scan is discarded.

## Timing
- Cycle 0 is the cycle frame_tick is sampled high in IDLE.
- busy=1 in cycles 1..N_BULLETS+1.
- Channel k is evaluated in cycle k+1.
- done, collision, hit_mask and hit_index are registered and valid at cycle N_BULLETS+1. done and collision are high only in that cycle.
- hit_mask and hit_index hold until the next REPORT.
- The next scan start is accepted from cycle N_BULLETS+2.
- invulnerable rises in the cycle after the collision pulse. It falls in the cycle after the frame_tick that takes the counter to 0.
- All outputs are registered, with no combinational input-to-output paths.

## Test plan
1. Boundary of radius, N=8, only ch3 active. Player (100,100), bullet (109,112) gives 81+144=225: tick → cycle 9 has done=1, collision=1, hit_mask=0x08, hit_index=3, hit_count=1. Repeat after invuln expires with bullet (110,112), giving 244: hit_mask=0, collision=0.
2. Sign symmetry. Player (200,50), bullets ch0 (191,38) and ch1 (209,62), both active → hit_mask=0x03, hit_index=0. Player at (5,5), bullet (0,0) → hit with no wrap artefacts.
3. Invulnerability, INVULN_FRAMES=3. Hit on frame 1 → collision pulse, invulnerable=1. Hits on frames 2–3 → hit_mask set, collision=0, hit_count stays 1. After the third tick following the hit, invulnerable=0. The next hit → collision=1, hit_count=2.
4. Inactive and overlapping channels. Bullet overlapping the player with bullet_active=0 → hit_mask bit 0, no collision. All 8 active and overlapping → hit_mask=0xFF, hit_index=0.
5. Tick while busy. Second frame_tick at cycle 4 → no restart, done only at cycle 9. Invuln counter decrements once for that tick.
6. Reset mid-scan. reset at cycle 5 with a pending hit → next cycle busy=0, done never pulses, all outputs 0. A new tick then gives a clean scan.

Source files
------------

// File: rtl/collision_scanner.sv
// collision_scanner: per-frame multi-bullet collision detector.
// Snapshots the player and bullet positions on frame_tick, checks one bullet
// per clock against a circular hit radius, then reports a hit mask, the lowest
// hit channel and a collision event. Uses a frame-based invulnerability window.
module collision_scanner #(
    parameter int unsigned N_BULLETS     = 8,
    parameter int unsigned COORD_W       = 10,
    parameter int unsigned RADIUS        = 15,
    parameter int unsigned INVULN_FRAMES = 60,
    localparam int unsigned IDX_W        = (N_BULLETS > 1) ? $clog2(N_BULLETS) : 1
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           frame_tick,
    input  logic [COORD_W-1:0]             player_x,
    input  logic [COORD_W-1:0]             player_y,
    input  logic [N_BULLETS*COORD_W-1:0]   bullet_x,
    input  logic [N_BULLETS*COORD_W-1:0]   bullet_y,
    input  logic [N_BULLETS-1:0]           bullet_active,
    output logic                           busy,
    output logic                           done,
    output logic [N_BULLETS-1:0]           hit_mask,
    output logic [IDX_W-1:0]               hit_index,
    output logic                           collision,
    output logic                           invulnerable,
    output logic [7:0]                     hit_count
);

    typedef enum logic [1:0] {IDLE, SCAN, REPORT} state_t;

    localparam logic [63:0] R2         = 64'(RADIUS) * 64'(RADIUS);
    localparam logic [7:0]  INV_LOAD   = 8'(INVULN_FRAMES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_BULLETS - 1);

    state_t                          state_q, state_d;
    logic [COORD_W-1:0]              px_q, px_d, py_q, py_d;
    logic [N_BULLETS*COORD_W-1:0]    bx_q, bx_d, by_q, by_d;
    logic [N_BULLETS-1:0]            act_q, act_d;
    logic [IDX_W-1:0]                idx_q, idx_d;
    logic [N_BULLETS-1:0]            acc_q, acc_d;
    logic                            busy_q, busy_d;
    logic                            done_q, done_d;
    logic                            collision_q, collision_d;
    logic [N_BULLETS-1:0]            hit_mask_q, hit_mask_d;
    logic [IDX_W-1:0]                hit_index_q, hit_index_d;
    logic [7:0]                      hit_count_q, hit_count_d;
    logic [7:0]                      inv_cnt_q, inv_cnt_d;
    logic                            invulnerable_q, invulnerable_d;

    logic [COORD_W-1:0]              cur_bx, cur_by, dx, dy;
    logic [2*COORD_W-1:0]            dx2, dy2;
    logic [2*COORD_W:0]              dist2;
    logic                            ch_hit;

    // Distance test for the channel currently selected by the scan index
    always_comb begin
        cur_bx = bx_q[idx_q*COORD_W +: COORD_W];
        cur_by = by_q[idx_q*COORD_W +: COORD_W];
        dx     = (px_q >= cur_bx) ? (px_q - cur_bx) : (cur_bx - px_q);
        dy     = (py_q >= cur_by) ? (py_q - cur_by) : (cur_by - py_q);
        dx2    = {{COORD_W{1'b0}}, dx} * {{COORD_W{1'b0}}, dx};
        dy2    = {{COORD_W{1'b0}}, dy} * {{COORD_W{1'b0}}, dy};
        dist2  = {1'b0, dx2} + {1'b0, dy2};
        ch_hit = act_q[idx_q] && (64'(dist2) <= R2);
    end

    // Scan FSM: snapshot, per-channel accumulation and result reporting
    always_comb begin
        state_d     = state_q;
        px_d        = px_q;
        py_d        = py_q;
        bx_d        = bx_q;
        by_d        = by_q;
        act_d       = act_q;
        idx_d       = idx_q;
        acc_d       = acc_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        collision_d = 1'b0;
        hit_mask_d  = hit_mask_q;
        hit_index_d = hit_index_q;
        hit_count_d = hit_count_q;
        case (state_q)
            IDLE: begin
                if (frame_tick) begin
                    px_d    = player_x;
                    py_d    = player_y;
                    bx_d    = bullet_x;
                    by_d    = bullet_y;
                    act_d   = bullet_active;
                    idx_d   = '0;
                    acc_d   = '0;
                    busy_d  = 1'b1;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                acc_d[idx_q] = acc_q[idx_q] | ch_hit;
                if (idx_q == LAST_IDX) begin
                    // Results are registered here so they appear in the REPORT cycle
                    state_d     = REPORT;
                    done_d      = 1'b1;
                    hit_mask_d  = acc_d;
                    hit_index_d = '0;
                    for (int unsigned i = N_BULLETS; i > 0; i--) begin
                        if (acc_d[i-1]) hit_index_d = IDX_W'(i - 1);
                    end
                    if ((|acc_d) && (inv_cnt_q == 8'd0)) begin
                        collision_d = 1'b1;
                        if (hit_count_q != 8'hFF) hit_count_d = hit_count_q + 8'd1;
                    end
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            REPORT: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // Invulnerability counter: collision load has priority over the frame decrement
    always_comb begin
        inv_cnt_d = inv_cnt_q;
        if ((state_q == REPORT) && collision_q) begin
            inv_cnt_d = INV_LOAD;
        end else if (frame_tick && (inv_cnt_q != 8'd0)) begin
            inv_cnt_d = inv_cnt_q - 8'd1;
        end
        invulnerable_d = (inv_cnt_d != 8'd0);
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            px_q           <= '0;
            py_q           <= '0;
            bx_q           <= '0;
            by_q           <= '0;
            act_q          <= '0;
            idx_q          <= '0;
            acc_q          <= '0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            collision_q    <= 1'b0;
            hit_mask_q     <= '0;
            hit_index_q    <= '0;
            hit_count_q    <= '0;
            inv_cnt_q      <= '0;
            invulnerable_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            px_q           <= px_d;
            py_q           <= py_d;
            bx_q           <= bx_d;
            by_q           <= by_d;
            act_q          <= act_d;
            idx_q          <= idx_d;
            acc_q          <= acc_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            collision_q    <= collision_d;
            hit_mask_q     <= hit_mask_d;
            hit_index_q    <= hit_index_d;
            hit_count_q    <= hit_count_d;
            inv_cnt_q      <= inv_cnt_d;
            invulnerable_q <= invulnerable_d;
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign collision    = collision_q;
    assign hit_mask     = hit_mask_q;
    assign hit_index    = hit_index_q;
    assign hit_count    = hit_count_q;
    assign invulnerable = invulnerable_q;

endmodule

// File: tb/tb_collision_scanner.sv
// Testbench for collision_scanner: scoreboard of expected scan results,
// one task per scenario, reference distance and invulnerability model.
module tb_collision_scanner;

    localparam int N   = 8;
    localparam int W   = 10;
    localparam int INV = 3;

    logic             clk = 1'b0;
    logic             reset;
    logic             frame_tick;
    logic [W-1:0]     player_x, player_y;
    logic [N*W-1:0]   bullet_x, bullet_y;
    logic [N-1:0]     bullet_active;
    logic             busy, done, collision, invulnerable;
    logic [N-1:0]     hit_mask;
    logic [2:0]       hit_index;
    logic [7:0]       hit_count;

    collision_scanner #(
        .N_BULLETS(N),
        .COORD_W(W),
        .RADIUS(15),
        .INVULN_FRAMES(INV)
    ) dut (
        .clk(clk),
        .reset(reset),
        .frame_tick(frame_tick),
        .player_x(player_x),
        .player_y(player_y),
        .bullet_x(bullet_x),
        .bullet_y(bullet_y),
        .bullet_active(bullet_active),
        .busy(busy),
        .done(done),
        .hit_mask(hit_mask),
        .hit_index(hit_index),
        .collision(collision),
        .invulnerable(invulnerable),
        .hit_count(hit_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [N-1:0] mask;
        logic [2:0]   idx;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   model_inv = 0;
    int   model_cnt = 0;
    int   px, py;
    int   bxa[N];
    int   bya[N];
    logic [N-1:0] act;

    function automatic bit ref_hit(int ax, int ay, int bx, int by);
        int dx, dy;
        dx = (ax > bx) ? ax - bx : bx - ax;
        dy = (ay > by) ? ay - by : by - ay;
        return (dx*dx + dy*dy) <= 225;
    endfunction

    task automatic apply_inputs();
        player_x = W'(px);
        player_y = W'(py);
        for (int k = 0; k < N; k++) begin
            bullet_x[k*W +: W] = W'(bxa[k]);
            bullet_y[k*W +: W] = W'(bya[k]);
        end
        bullet_active = act;
    endtask

    task automatic place_all(int x, int y, logic [N-1:0] a);
        for (int k = 0; k < N; k++) begin
            bxa[k] = x;
            bya[k] = y;
        end
        act = a;
    endtask

    // One full frame: tick, push expectation, wait for done, compare.
    task automatic scan(input int extra_tick_cyc);
        exp_t e;
        int   cyc;
        bit   got;
        bit   exp_coll;
        apply_inputs();
        @(negedge clk);
        frame_tick = 1'b1;
        e.mask = '0;
        e.idx  = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (act[k] && ref_hit(px, py, bxa[k], bya[k])) begin
                e.mask[k] = 1'b1;
                e.idx     = 3'(k);
            end
        end
        if (model_inv > 0) model_inv--;
        sb.push_back(e);
        cyc = 0;
        got = 0;
        while (cyc < 20 && !got) begin
            @(negedge clk);
            cyc++;
            frame_tick = (cyc == extra_tick_cyc);
            if (cyc == extra_tick_cyc && model_inv > 0) model_inv--;
            if (cyc == 1) begin
                tests++;
                if (busy !== 1'b1) begin
                    fails++;
                    $display("FAIL busy_start: got %b want 1", busy);
                end
            end
            if (done === 1'b1) begin
                got = 1;
                tests++;
                if (cyc != N + 1) begin
                    fails++;
                    $display("FAIL done_cycle: got %0d want %0d", cyc, N + 1);
                end
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL scoreboard_empty: got 0 entries want 1");
                end else begin
                    e = sb.pop_front();
                    exp_coll = (e.mask != 0) && (model_inv == 0);
                    if (exp_coll) begin
                        model_inv = INV;
                        if (model_cnt < 255) model_cnt++;
                    end
                    tests += 4;
                    if (hit_mask !== e.mask) begin
                        fails++;
                        $display("FAIL hit_mask: got %h want %h", hit_mask, e.mask);
                    end
                    if (hit_index !== e.idx) begin
                        fails++;
                        $display("FAIL hit_index: got %0d want %0d", hit_index, e.idx);
                    end
                    if (collision !== exp_coll) begin
                        fails++;
                        $display("FAIL collision: got %b want %b", collision, exp_coll);
                    end
                    if (hit_count !== 8'(model_cnt)) begin
                        fails++;
                        $display("FAIL hit_count: got %0d want %0d", hit_count, model_cnt);
                    end
                end
            end
        end
        frame_tick = 1'b0;
        if (!got) begin
            tests++;
            fails++;
            $display("FAIL done_timeout: got no done want done at cycle %0d", N + 1);
        end else begin
            @(negedge clk);
            tests += 4;
            if (done !== 1'b0) begin
                fails++;
                $display("FAIL done_pulse: got %b want 0", done);
            end
            if (collision !== 1'b0) begin
                fails++;
                $display("FAIL coll_pulse: got %b want 0", collision);
            end
            if (busy !== 1'b0) begin
                fails++;
                $display("FAIL busy_end: got %b want 0", busy);
            end
            if (invulnerable !== (model_inv != 0)) begin
                fails++;
                $display("FAIL invulnerable: got %b want %b", invulnerable, model_inv != 0);
            end
        end
    endtask

    task automatic check_all_zero(string tag);
        tests++;
        if (busy !== 1'b0 || done !== 1'b0 || collision !== 1'b0 || invulnerable !== 1'b0 ||
            hit_mask !== '0 || hit_index !== '0 || hit_count !== '0) begin
            fails++;
            $display("FAIL %s: got busy=%b done=%b coll=%b inv=%b mask=%h idx=%0d cnt=%0d want all 0",
                     tag, busy, done, collision, invulnerable, hit_mask, hit_index, hit_count);
        end
    endtask

    task automatic test_reset();
        reset      = 1'b1;
        frame_tick = 1'b0;
        px = 0; py = 0;
        place_all(0, 0, '0);
        apply_inputs();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check_all_zero("reset_state");
        model_inv = 0;
        model_cnt = 0;
    endtask

    task automatic test_radius();
        px = 100; py = 100;
        place_all(500, 500, 8'h08);
        bxa[3] = 109; bya[3] = 112;
        scan(0);
        act = '0;
        repeat (3) scan(0);
        act = 8'h08;
        bxa[3] = 110; bya[3] = 112;
        scan(0);
    endtask

    task automatic test_symmetry();
        px = 200; py = 50;
        place_all(600, 600, 8'h03);
        bxa[0] = 191; bya[0] = 38;
        bxa[1] = 209; bya[1] = 62;
        scan(0);
        px = 5; py = 5;
        place_all(1000, 1000, 8'h81);
        bxa[0] = 0; bya[0] = 0;
        bxa[7] = 1020; bya[7] = 1020;
        scan(0);
    endtask

    task automatic test_invuln();
        px = 300; py = 300;
        place_all(900, 900, '0);
        repeat (3) scan(0);
        act = 8'h01;
        bxa[0] = 305; bya[0] = 296;
        repeat (5) scan(0);
    endtask

    task automatic test_inactive();
        px = 400; py = 400;
        place_all(400, 400, '0);
        scan(0);
        act = 8'hFF;
        scan(0);
    endtask

    task automatic test_busy_tick();
        px = 50; py = 50;
        place_all(800, 800, '0);
        repeat (3) scan(0);
        act = 8'h20;
        bxa[5] = 50; bya[5] = 50;
        scan(0);
        act = '0;
        scan(4);
        scan(0);
    endtask

    task automatic test_reset_mid();
        int seen;
        exp_t e;
        px = 10; py = 10;
        place_all(10, 10, 8'h04);
        apply_inputs();
        @(negedge clk);
        frame_tick = 1'b1;
        e.mask = 8'h04;
        e.idx  = 3'd2;
        sb.push_back(e);
        @(negedge clk);
        frame_tick = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        sb.delete();
        model_inv = 0;
        model_cnt = 0;
        check_all_zero("reset_mid_scan");
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (done === 1'b1) seen++;
        end
        tests++;
        if (seen != 0) begin
            fails++;
            $display("FAIL done_after_reset: got %0d pulses want 0", seen);
        end
        scan(0);
    endtask

    initial begin
        test_reset();
        test_radius();
        test_symmetry();
        test_invuln();
        test_inactive();
        test_busy_tick();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
